// File: rtl/pwm_multi.sv
// pwm_multi: N-channel PWM generator with one shared clock prescaler.
//
// A prescaler tick advances every running channel's period counter. Period
// and duty sit in per-channel shadow registers that reload only when the
// channel enables or wraps, so mid-period reprogramming never glitches pwm_o.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-high
//   enable_i      per-channel enable
//   mode_i        per-channel 1 = center-aligned (only with PWM_CENTER_ALIGN_EN)
//   prescaler_i   one tick every prescaler_i+1 clocks
//   pwm_period_i  per-channel period in ticks, channel k at [k*CNT_W +: CNT_W]
//   duty_cycle_i  per-channel high time in ticks, same packing
//   pwm_o         registered PWM outputs
//   period_end_o  one-clk pulse after a channel wraps
//
// Optional build macro: PWM_CENTER_ALIGN_EN adds mode_i and up/down counting.
// Without it every channel is edge-aligned.
//
// Channel FSM:
//   state       | meaning
//   ST_DISABLED | counter cleared, outputs low, shadows load on enable
//   ST_RUN      | counting ticks, shadows reload on wrap
module pwm_multi #(
  parameter int CH_NUM  = 3,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CH_NUM-1:0]       enable_i,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic [CH_NUM-1:0]       mode_i,
`endif
  input  logic [PRESC_W-1:0]      prescaler_i,
  input  logic [CH_NUM*CNT_W-1:0] pwm_period_i,
  input  logic [CH_NUM*CNT_W-1:0] duty_cycle_i,
  output logic [CH_NUM-1:0]       pwm_o,
  output logic [CH_NUM-1:0]       period_end_o
);

  typedef enum logic {ST_DISABLED = 1'b0, ST_RUN = 1'b1} state_t;

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic               any_en;
  logic               tick;

  state_t             state_q [CH_NUM];
  state_t             state_d [CH_NUM];
  logic [CNT_W-1:0]   cnt_q   [CH_NUM];
  logic [CNT_W-1:0]   cnt_d   [CH_NUM];
  logic [CNT_W-1:0]   per_q   [CH_NUM];
  logic [CNT_W-1:0]   per_d   [CH_NUM];
  logic [CNT_W-1:0]   duty_q  [CH_NUM];
  logic [CNT_W-1:0]   duty_d  [CH_NUM];
  logic [CH_NUM-1:0]  center_q, center_d;
  logic [CH_NUM-1:0]  down_q, down_d;
  logic [CH_NUM-1:0]  pwm_q, pwm_d;
  logic [CH_NUM-1:0]  pend_q, pend_d;
  logic [CH_NUM-1:0]  wrap;
  logic [CH_NUM-1:0]  mode_w;

`ifdef PWM_CENTER_ALIGN_EN
  assign mode_w = mode_i;
`else
  assign mode_w = '0;
`endif

  // The >= compare lets a lowered prescaler take effect immediately.
  always_comb begin
    any_en = |enable_i;
    tick   = any_en && (presc_cnt_q >= prescaler_i);
    if (!any_en || tick) presc_cnt_d = '0;
    else                 presc_cnt_d = presc_cnt_q + PRESC_W'(1);
  end

  always_comb begin
    for (int k = 0; k < CH_NUM; k++) begin
      state_d[k]  = state_q[k];
      cnt_d[k]    = cnt_q[k];
      per_d[k]    = per_q[k];
      duty_d[k]   = duty_q[k];
      center_d[k] = center_q[k];
      down_d[k]   = down_q[k];
      pwm_d[k]    = 1'b0;
      pend_d[k]   = 1'b0;
      wrap[k]     = 1'b0;

      case (state_q[k])
        ST_DISABLED: begin
          cnt_d[k]  = '0;
          down_d[k] = 1'b0;
          if (enable_i[k]) begin
            state_d[k]  = ST_RUN;
            per_d[k]    = pwm_period_i[k*CNT_W +: CNT_W];
            duty_d[k]   = duty_cycle_i[k*CNT_W +: CNT_W];
            center_d[k] = mode_w[k];
          end
        end
        ST_RUN: begin
          // A zero period parks the channel: no count, no output, no wrap.
          pwm_d[k] = (per_q[k] != '0) && (cnt_q[k] < duty_q[k]);
          if (!enable_i[k]) begin
            state_d[k] = ST_DISABLED;
          end else if (tick && (per_q[k] != '0)) begin
            if (!down_q[k]) begin
              if (cnt_q[k] == per_q[k] - CNT_W'(1)) begin
                // Center mode repeats the top value on the turnaround tick.
                if (center_q[k]) down_d[k] = 1'b1;
                else             wrap[k]   = 1'b1;
              end else begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
              end
            end else begin
              if (cnt_q[k] == '0) wrap[k]  = 1'b1;
              else                cnt_d[k] = cnt_q[k] - CNT_W'(1);
            end
            if (wrap[k]) begin
              cnt_d[k]    = '0;
              down_d[k]   = 1'b0;
              pend_d[k]   = 1'b1;
              per_d[k]    = pwm_period_i[k*CNT_W +: CNT_W];
              duty_d[k]   = duty_cycle_i[k*CNT_W +: CNT_W];
              center_d[k] = mode_w[k];
            end
          end
        end
        default: state_d[k] = ST_DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt_q <= '0;
      center_q    <= '0;
      down_q      <= '0;
      pwm_q       <= '0;
      pend_q      <= '0;
      for (int k = 0; k < CH_NUM; k++) begin
        state_q[k] <= ST_DISABLED;
        cnt_q[k]   <= '0;
        per_q[k]   <= '0;
        duty_q[k]  <= '0;
      end
    end else begin
      presc_cnt_q <= presc_cnt_d;
      center_q    <= center_d;
      down_q      <= down_d;
      pwm_q       <= pwm_d;
      pend_q      <= pend_d;
      for (int k = 0; k < CH_NUM; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
        per_q[k]   <= per_d[k];
        duty_q[k]  <= duty_d[k];
      end
    end
  end

  assign pwm_o        = pwm_q;
  assign period_end_o = pend_q;

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: self-checking bench for pwm_multi (CH_NUM=3, 32-bit widths).
// Table of waveform-statistics vectors, hand-written corner sequences, and a
// randomized run compared each clock against a tick/phase reference model.
module tb_pwm_multi;
  localparam int CH = 3;
  localparam int CW = 32;
  localparam int PW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [CH-1:0]    enable_i;
`ifdef PWM_CENTER_ALIGN_EN
  logic [CH-1:0]    mode_i;
`endif
  logic [PW-1:0]    prescaler_i;
  logic [CH*CW-1:0] pwm_period_i;
  logic [CH*CW-1:0] duty_cycle_i;
  logic [CH-1:0]    pwm_o;
  logic [CH-1:0]    period_end_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_multi #(.CH_NUM(CH), .CNT_W(CW), .PRESC_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
`ifdef PWM_CENTER_ALIGN_EN
    .mode_i       (mode_i),
`endif
    .prescaler_i  (prescaler_i),
    .pwm_period_i (pwm_period_i),
    .duty_cycle_i (duty_cycle_i),
    .pwm_o        (pwm_o),
    .period_end_o (period_end_o)
  );

  // Reference model: each running channel is at some tick phase within its
  // latched period; the output is "phase below duty", delayed one clock.
  int unsigned m_presc;
  bit          m_run  [CH];
  int unsigned m_per  [CH];
  int unsigned m_duty [CH];
  int unsigned m_ph   [CH];
  bit          m_pwm  [CH];
  bit          m_pend [CH];

  function automatic void model_reset();
    m_presc = 0;
    for (int k = 0; k < CH; k++) begin
      m_run[k] = 0; m_per[k] = 0; m_duty[k] = 0;
      m_ph[k] = 0;  m_pwm[k] = 0; m_pend[k] = 0;
    end
  endfunction

  function automatic void model_step();
    bit          any;
    bit          tk;
    int unsigned p;
    int unsigned d;
    if (rst) begin
      model_reset();
      return;
    end
    any = |enable_i;
    tk  = any && (m_presc >= prescaler_i);
    m_presc = (tk || !any) ? 0 : m_presc + 1;
    for (int k = 0; k < CH; k++) begin
      p = pwm_period_i[k*CW +: CW];
      d = duty_cycle_i[k*CW +: CW];
      m_pend[k] = 0;
      if (!m_run[k]) begin
        m_pwm[k] = 0;
        m_ph[k]  = 0;
        if (enable_i[k]) begin
          m_run[k] = 1; m_per[k] = p; m_duty[k] = d;
        end
      end else begin
        m_pwm[k] = (m_per[k] != 0) && (m_ph[k] < m_duty[k]);
        if (!enable_i[k]) m_run[k] = 0;
        else if (tk && m_per[k] != 0) begin
          m_ph[k] = (m_ph[k] + 1) % m_per[k];
          if (m_ph[k] == 0) begin
            m_pend[k] = 1; m_per[k] = p; m_duty[k] = d;
          end
        end
      end
    end
  endfunction

  function automatic logic [CH-1:0] model_pwm();
    logic [CH-1:0] v;
    for (int k = 0; k < CH; k++) v[k] = m_pwm[k];
    return v;
  endfunction

  function automatic logic [CH-1:0] model_pend();
    logic [CH-1:0] v;
    for (int k = 0; k < CH; k++) v[k] = m_pend[k];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_ch(input int k, input int per, input int duty);
    pwm_period_i[k*CW +: CW] = CW'(per);
    duty_cycle_i[k*CW +: CW] = CW'(duty);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable_i = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    int presc;
    int per;
    int duty;
    int window;
    int exp_high;
    int exp_pend;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int highs, pends, others, both;

    vecs[0] = '{0, 10, 3, 100, 30, 10};
    vecs[1] = '{4, 10, 3, 500, 150, 10};
    vecs[2] = '{0, 10, 0, 50, 0, 5};
    vecs[3] = '{0, 10, 12, 50, 50, 5};
    vecs[4] = '{0, 0, 3, 50, 0, 0};
    vecs[5] = '{1, 4, 1, 80, 20, 10};
    vecs[6] = '{2, 5, 5, 60, 60, 4};

    model_reset();
    rst = 1'b1;
    enable_i = '0;
    prescaler_i = '0;
    pwm_period_i = '0;
    duty_cycle_i = '0;
`ifdef PWM_CENTER_ALIGN_EN
    mode_i = '0;
`endif

    // Reset held with every input nonzero.
    enable_i = '1;
    prescaler_i = 2;
    for (int k = 0; k < CH; k++) set_ch(k, 5, 3);
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_pwm", 32'(pwm_o), 0);
      check("rst_pend", 32'(period_end_o), 0);
    end
    rst = 1'b0;
    step();
    check("rst_rel_pwm", 32'(pwm_o), 0);
    check("rst_rel_pend", 32'(period_end_o), 0);

    // Waveform statistics over whole periods on ch0; ch1/ch2 must stay idle.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      for (int k = 0; k < CH; k++) set_ch(k, 0, 0);
      prescaler_i = PW'(vecs[v].presc);
      set_ch(0, vecs[v].per, vecs[v].duty);
      set_ch(1, 10, 5);
      enable_i = 3'b001;
      for (int i = 0; i < 60; i++) step();
      highs = 0; pends = 0; others = 0;
      for (int i = 0; i < vecs[v].window; i++) begin
        step();
        highs += int'(pwm_o[0]);
        pends += int'(period_end_o[0]);
        others += int'(pwm_o[2:1] != 0 || period_end_o[2:1] != 0);
      end
      check($sformatf("vec%0d_high", v), 32'(highs), 32'(vecs[v].exp_high));
      check($sformatf("vec%0d_pend", v), 32'(pends), 32'(vecs[v].exp_pend));
      check($sformatf("vec%0d_idle", v), 32'(others), 0);
    end

    // Duty 3 -> 7 mid-period: new duty only after the next wrap.
    do_reset();
    prescaler_i = '0;
    for (int k = 0; k < CH; k++) set_ch(k, 0, 0);
    set_ch(0, 10, 3);
    enable_i = 3'b001;
    step();
    check("dchg_start", 32'(pwm_o[0]), 0);
    for (int i = 1; i <= 20; i++) begin
      step();
      check($sformatf("dchg_pwm%0d", i), 32'(pwm_o[0]),
            32'((i >= 1 && i <= 3) || (i >= 11 && i <= 17)));
      check($sformatf("dchg_pend%0d", i), 32'(period_end_o[0]), 32'(i == 10 || i == 20));
      if (i == 2) set_ch(0, 10, 7);
    end

    // Enable dropped while high.
    do_reset();
    set_ch(0, 10, 5);
    enable_i = 3'b001;
    for (int i = 0; i < 3; i++) step();
    check("drop_high_before", 32'(pwm_o[0]), 1);
    enable_i = 3'b000;
    step();
    step();
    check("drop_low_2clk", 32'(pwm_o[0]), 0);
    for (int i = 0; i < 12; i++) step();
    check("drop_stay_low", 32'(pwm_o), 0);
    check("drop_no_pend", 32'(period_end_o), 0);

    // Reset mid-operation.
    enable_i = 3'b001;
    for (int i = 0; i < 12; i++) step();
    rst = 1'b1;
    step();
    check("midrst_pwm", 32'(pwm_o), 0);
    check("midrst_pend", 32'(period_end_o), 0);
    rst = 1'b0;

`ifdef PWM_CENTER_ALIGN_EN
    // Center-aligned: 4 high clks every 16, wrap pulse inside the high run.
    do_reset();
    mode_i = 3'b001;
    prescaler_i = '0;
    set_ch(0, 8, 2);
    enable_i = 3'b001;
    for (int i = 0; i < 40; i++) step();
    highs = 0; pends = 0; both = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      highs += int'(pwm_o[0]);
      pends += int'(period_end_o[0]);
      both  += int'(pwm_o[0] && period_end_o[0]);
    end
    check("ctr_high", 32'(highs), 16);
    check("ctr_pend", 32'(pends), 4);
    check("ctr_centred", 32'(both), 4);
    mode_i = '0;
`endif

    // Randomized run against the reference model.
    do_reset();
    prescaler_i = 1;
    for (int k = 0; k < CH; k++) set_ch(k, 6, 2);
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) < 2) enable_i = CH'($urandom);
      if ($urandom_range(0, 99) < 3) prescaler_i = PW'($urandom_range(0, 3));
      for (int k = 0; k < CH; k++)
        if ($urandom_range(0, 99) < 5)
          set_ch(k, int'($urandom_range(0, 9)), int'($urandom_range(0, 11)));
      step();
      check("rand_pwm", 32'(pwm_o), 32'(model_pwm()));
      check("rand_pend", 32'(period_end_o), 32'(model_pend()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
